// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: async FIFO write-side pointer, address and status-flag controller
// Ports:
//   wclk, hw_rst (async, active-high), sw_rst (sync, write side only)
//   write_enable, wdata[31:0], afull_value[ADDR_W-1:0] (almost-full threshold in free entries)
//   rptr_gray_sync[PTR_W-1:0]  read pointer (Gray) already synchronized into wclk
//   mem_wen, mem_waddr, mem_wdata  memory write port
//   wptr_gray  registered Gray write pointer for the read-domain synchronizer
//   wfull, wr_almost_ful, overflow, fifo_write_count, wr_level  status
// Optional: define FIFO_WR_OVERFLOW_STICKY_EN to hold overflow until reset;
// otherwise overflow pulses once per rejected write cycle.
module fifo_wr_ctrl #(
  parameter int ADDR_W = 5,
  parameter int PTR_W = ADDR_W + 1
) (
  input  logic              wclk,
  input  logic              hw_rst,
  input  logic              sw_rst,
  input  logic              write_enable,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] afull_value,
  input  logic [PTR_W-1:0]  rptr_gray_sync,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [PTR_W-1:0]  wptr_gray,
  output logic              wfull,
  output logic              wr_almost_ful,
  output logic              overflow,
  output logic [PTR_W-1:0]  fifo_write_count,
  output logic [PTR_W-1:0]  wr_level
);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(2 ** ADDR_W);
  logic [PTR_W-1:0] r_wbin, r_wptr_gray, r_count, r_level;
  logic             r_wfull, r_afull, r_ovf;
  logic             w_accept, w_reject;
  logic [PTR_W-1:0] w_wbin_next, w_wgray_next, w_rbin, w_level_next, w_free;
  assign w_accept = write_enable & ~r_wfull & ~sw_rst;
  assign w_reject = write_enable & r_wfull;
  assign w_wbin_next = r_wbin + PTR_W'(w_accept);
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
  // Each binary bit is the XOR of all Gray bits at and above it.
  for (genvar i = 0; i < PTR_W; i++) begin : g_g2b
    assign w_rbin[i] = ^rptr_gray_sync[PTR_W-1:i];
  end
  assign w_level_next = w_wbin_next - w_rbin;
  assign w_free = DEPTH_P - w_level_next;
  always_ff @(posedge wclk or posedge hw_rst) begin
    if (hw_rst) begin
      r_wbin <= '0;
      r_wptr_gray <= '0;
      r_count <= '0;
      r_level <= '0;
      r_wfull <= 1'b0;
      r_afull <= 1'b0;
      r_ovf <= 1'b0;
    end else if (sw_rst) begin
      r_wbin <= '0;
      r_wptr_gray <= '0;
      r_count <= '0;
      r_level <= '0;
      r_wfull <= 1'b0;
      r_afull <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_wbin <= w_wbin_next;
      r_wptr_gray <= w_wgray_next;
      r_count <= r_count + PTR_W'(w_accept);
      r_level <= w_level_next;
      // Full when the pointers differ only in the wrap bit: top two Gray bits inverted.
      r_wfull <= w_wgray_next == {~rptr_gray_sync[PTR_W-1:PTR_W-2], rptr_gray_sync[PTR_W-3:0]};
      r_afull <= w_free <= {1'b0, afull_value};
`ifdef FIFO_WR_OVERFLOW_STICKY_EN
      r_ovf <= r_ovf | w_reject;
`else
      r_ovf <= w_reject;
`endif
    end
  end
  assign mem_wen = w_accept;
  assign mem_waddr = r_wbin[ADDR_W-1:0];
  assign mem_wdata = wdata;
  assign wptr_gray = r_wptr_gray;
  assign wfull = r_wfull;
  assign wr_almost_ful = r_afull;
  assign overflow = r_ovf;
  assign fifo_write_count = r_count;
  assign wr_level = r_level;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: randomized self-checking bench for fifo_wr_ctrl against an occupancy model
module tb_fifo_wr_ctrl;
  logic        wclk = 0, hw_rst = 1, sw_rst = 0, write_enable = 0;
  logic [31:0] wdata = 0;
  logic [4:0]  afull_value = 4;
  logic [5:0]  rptr_gray_sync = 0;
  logic        mem_wen, wfull, wr_almost_ful, overflow;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [5:0]  wptr_gray, fifo_write_count, wr_level;
  int total = 0, bad = 0;
  int m_w = 0, m_r = 0, m_level = 0;
  bit m_full = 0, m_afull = 0, m_ovf = 0;
  fifo_wr_ctrl dut (
    .wclk(wclk), .hw_rst(hw_rst), .sw_rst(sw_rst), .write_enable(write_enable),
    .wdata(wdata), .afull_value(afull_value), .rptr_gray_sync(rptr_gray_sync),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wptr_gray(wptr_gray),
    .wfull(wfull), .wr_almost_ful(wr_almost_ful), .overflow(overflow),
    .fifo_write_count(fifo_write_count), .wr_level(wr_level)
  );
  always #5 wclk = ~wclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int gray(input int v);
    return (v ^ (v >> 1)) & 63;
  endfunction
  task automatic check_regs(input string tag);
    check({tag, ".gray"}, wptr_gray, gray(m_w));
    check({tag, ".full"}, wfull, m_full);
    check({tag, ".afull"}, wr_almost_ful, m_afull);
    check({tag, ".ovf"}, overflow, m_ovf);
    check({tag, ".cnt"}, fifo_write_count, m_w);
    check({tag, ".lvl"}, wr_level, m_level);
  endtask
  task automatic model_reset();
    m_w = 0; m_r = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
  endtask
  // One wclk cycle; entered and left 1 time unit after a rising edge.
  task automatic step(input bit we, input bit swr, input string tag);
    bit acc, rej;
    logic [5:0] prev_gray;
    write_enable = we;
    sw_rst = swr;
    wdata = $urandom;
    rptr_gray_sync = 6'(gray(m_r));
    acc = we && !m_full && !swr;
    rej = we && m_full;
    #3;
    check({tag, ".wen"}, mem_wen, acc);
    check({tag, ".waddr"}, mem_waddr, m_w % 32);
    check({tag, ".wdata"}, mem_wdata, wdata);
    prev_gray = wptr_gray;
    @(posedge wclk);
    #1;
    if (swr) model_reset();
    else begin
      m_w = (m_w + int'(acc)) % 64;
      m_level = (m_w - m_r + 64) % 64;
      m_full = m_level == 32;
      m_afull = (32 - m_level) <= int'(afull_value);
`ifdef FIFO_WR_OVERFLOW_STICKY_EN
      m_ovf = m_ovf || rej;
`else
      m_ovf = rej;
`endif
      if (acc) check({tag, ".gray1bit"}, $countones(prev_gray ^ wptr_gray), 1);
    end
    check_regs(tag);
  endtask
  initial begin
    #2;
    check_regs("rst");
    @(posedge wclk);
    #1;
    hw_rst = 0;
    for (int i = 0; i < 33; i++) step(1, 0, "fill");
    check("fill.full", wfull, 1);
    check("fill.lvl32", wr_level, 32);
    check("fill.ovf", overflow, 1);
    m_r = 1;
    step(1, 0, "rstep");
    check("rstep.lvl31", wr_level, 31);
    step(1, 0, "rstep_acc");
    for (int i = 0; i < 3; i++) step(1, 0, "ovf");
    step(0, 0, "ovf_idle");
`ifdef FIFO_WR_OVERFLOW_STICKY_EN
    check("ovf_sticky", overflow, 1);
`else
    check("ovf_pulse", overflow, 0);
`endif
    step(0, 1, "swr0");
    afull_value = 0;
    for (int i = 0; i < 10; i++) step(1, 0, "lvl10");
    check("lvl10", wr_level, 10);
    step(1, 1, "swr10");
    for (int i = 0; i < 64; i++) begin
      m_r = m_w;
      step(1, 0, "wrap");
      check("wrap.nofull", wfull, 0);
    end
    check("wrap.gray0", wptr_gray, 0);
    check("wrap.cnt0", fifo_write_count, 0);
    m_r = m_w;
    for (int i = 0; i < 400; i++) begin
      bit swr;
      afull_value = 5'($urandom);
      swr = $urandom_range(0, 60) == 0;
      if (swr) m_r = 0;
      else m_r = (m_r + $urandom_range(0, (m_w - m_r + 64) % 64 / 3)) % 64;
      step($urandom_range(0, 3) != 0, swr, "rand");
      if (swr) m_r = 0;
    end
    m_r = 0;
    step(0, 1, "swr1");
    for (int i = 0; i < 5; i++) step(1, 0, "burst");
    #2;
    hw_rst = 1;
    #1;
    model_reset();
    check_regs("hwrst");
    @(posedge wclk);
    #1;
    write_enable = 0;
    hw_rst = 0;
    step(1, 0, "post_hw");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-domain pointer and flag controller of the async FIFO. It sits directly behind the FIFO write port and produces the status signals that the write agent drives against and monitors:
- inputs: wdata, write_enable, afull_value, sw_rst
- outputs: wfull, wr_almost_ful, overflow, fifo_write_count, wr_level

It qualifies writes, generates the memory write address/strobe, and exports a Gray write pointer for the read-domain synchronizer. It consumes the read pointer after it has already been 2-FF synchronized into wclk.

Parameters:
- ADDR_W, 5, memory address width; DEPTH = 2**ADDR_W = 32 entries.
- PTR_W, ADDR_W+1, pointer, level and count width (6); not overridden independently.

Ports:
- wclk  input  1  write-domain clock; all state on posedge.
- hw_rst  input  1  asynchronous active-high reset.
- sw_rst  input  1  synchronous software reset; write side only.
- write_enable  input  1  write request from producer.
- wdata  input  32  write data; passed to memory unregistered.
- afull_value  input  5  almost-full threshold, in free entries.
- rptr_gray_sync  input  PTR_W  read pointer, Gray, already synchronized to wclk.
- mem_wen  output  1  memory write strobe (combinational).
- mem_waddr  output  ADDR_W  memory write address (registered).
- mem_wdata  output  32  equals wdata.
- wptr_gray  output  PTR_W  registered Gray write pointer to read-domain sync.
- wfull  output  1  FIFO full.
- wr_almost_ful  output  1  free entries <= afull_value.
- overflow  output  1  write attempted while full.
- fifo_write_count  output  PTR_W  accepted writes since reset, wraps mod 64.
- wr_level  output  PTR_W  occupancy as seen by write domain, 0..32.

Behaviour:
- Clock and reset: one clock, wclk. hw_rst is asynchronous, active-high.
- Reset values (hw_rst asserted, or sw_rst sampled high):
  - wbin = 0, wptr_gray = 0, mem_waddr = 0.
  - wfull = 0, wr_almost_ful = 0, overflow = 0.
  - fifo_write_count = 0, wr_level = 0.
- hw_rst clears immediately, independent of wclk. sw_rst clears on the next posedge and overrides a same-cycle write.
- Accept rule:
  - accept = write_enable & ~wfull & ~sw_rst.
  - mem_wen = accept, combinational, same cycle.
  - Data is written at mem_waddr = wbin[ADDR_W-1:0].
- Pointer update on accept:
  - wbin_next = wbin + 1, modulo 2**PTR_W; the MSB toggles each DEPTH writes.
  - Otherwise wbin_next = wbin.
  - wptr_gray <= wbin_next ^ (wbin_next >> 1). Registered, never glitching, exactly one bit changes per accept.
- Read pointer: rbin_sync = Gray-to-binary of rptr_gray_sync, combinational.
- Full flag, registered:
  - wfull <= (gray(wbin_next) == {~rptr_gray_sync[PTR_W-1:PTR_W-2], rptr_gray_sync[PTR_W-3:0]}).
  - Assertion takes effect the cycle after the DEPTH-th unread accept, so there is no write-through-full.
- Level and almost-full, registered:
  - wr_level <= wbin_next - rbin_sync, PTR_W-bit modular subtract, result 0..DEPTH.
  - wr_almost_ful <= (DEPTH - level_next) <= afull_value.
  - afull_value = 0 makes wr_almost_ful identical to wfull.
- Write count: fifo_write_count <= fifo_write_count + accept, wrapping 63 -> 0.
- Overflow: write_enable & wfull in a cycle -> no pointer change, no mem_wen, overflow set per the Optional Feature.
- Read pointer advance: a read-pointer change while full deasserts wfull and lowers wr_level on the next posedge. A simultaneous write in that same cycle is still rejected, because the decision uses the current wfull.
- Pessimism: wfull and wr_level lag true occupancy by the synchronizer latency; this is intended.
- sw_rst is write-side only. The system must reset the read side together with it; otherwise wr_level after sw_rst is undefined.

Optional Feature:
- Macro: FIFO_WR_OVERFLOW_STICKY_EN.
- Defined: overflow sets on the first rejected write and holds until hw_rst or sw_rst.
- Undefined: overflow is a one-cycle registered pulse for each rejected write cycle. Back-to-back rejected writes give a continuous high.

Test Plan:
- Fill with rptr_gray_sync held 0, write_enable high 33 cycles:
  - 32 mem_wen pulses, mem_waddr 0..31.
  - wfull = 1 after the 32nd accept; wr_level = 32, fifo_write_count = 32.
  - 33rd cycle: no mem_wen, overflow = 1.
- afull_value = 4, rptr held 0: wr_almost_ful rises after the 28th accept (wr_level = 28); wfull stays 0 until 32.
- While full, step rptr_gray_sync 000000 -> 000001: wfull = 0 and wr_level = 31 next cycle; a write in the step cycle is rejected, the following one is accepted.
- Wrap-around: 64 writes with rptr_gray_sync tracking wptr_gray each cycle:
  - wptr_gray returns to 000000, fifo_write_count wraps to 0.
  - wfull is never asserted; a single-bit Gray change is checked every accept.
- sw_rst pulsed at wr_level = 10 with write_enable high: all outputs 0 next cycle, no mem_wen in the sw_rst cycle.
- hw_rst asserted mid-burst between clock edges: all outputs 0 immediately, before the next wclk edge.
- Overflow macro both ways, 3 rejected writes then 1 idle cycle:
  - Sticky: overflow high until sw_rst.
  - Non-sticky: high 3 cycles, then 0.
